int2float_pipe: RTL and testbench



---
 rtl/int2float_pkg.sv | 23 ++
 rtl/int2float_pipe_lzd.sv | 20 ++
 rtl/int2float_pipe.sv | 158 +++++++++++++++
 tb/tb_int2float_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/int2float_pkg.sv
// Shared types and constants for the pipelined int-to-float converter.
// The result struct is sized by the package widths, which are the converter's default float format.
package int2float_pkg;

   localparam logic RND_TRUNC = 1'b0;
   localparam logic RND_RNE   = 1'b1;

   localparam int RES_EXP_W = 3;
   localparam int RES_MAN_W = 4;

   typedef struct packed {
      logic                 sign;
      logic [RES_EXP_W-1:0] exp;
      logic [RES_MAN_W-1:0] man;
      logic                 inexact;
      logic                 sat;
   } f_res_t;

   function automatic int max_exp(input int exp_w);
      return (1 << exp_w) - 1;
   endfunction

endpackage

// File: rtl/int2float_pipe_lzd.sv
// Combinational leading-one detector: index of the highest set bit plus an all-zero flag.
module lzd_prio #(
   parameter int W  = 11,
   parameter int PW = $clog2(W)
) (
   input  logic [W-1:0]  v,
   output logic [PW-1:0] p,
   output logic          zero
);

   // Ascending scan, so the highest set bit wins.
   always_comb begin
      p = '0;
      for (int i = 0; i < W; i++)
         if (v[i]) p = PW'(i);
   end

   assign zero = (v == '0);

endmodule

// File: rtl/int2float_pipe.sv
// Three-stage integer-to-small-float converter with valid/ready on both sides.
// S1 sign/magnitude, S2 leading-one detect, S3 shift/round/saturate into the output registers.
module int2float_pipe
   import int2float_pkg::*;
#(
   parameter int IN_W   = 11,
   parameter int MAN_W  = RES_MAN_W,
   parameter int EXP_W  = RES_EXP_W,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_rne,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic [MAN_W-1:0] out_man,
   output logic             out_inexact,
   output logic             out_sat
);

   localparam int PW   = $clog2(IN_W);
   localparam int EW   = (PW + 2 > EXP_W + 1) ? PW + 2 : EXP_W + 1;
   localparam int IW1  = IN_W + 1;
   localparam int MAXE = max_exp(EXP_W);

   logic s1_vld, s2_vld, o_vld;
   logic s1_en, s2_en, s3_en;

   // Each stage loads when empty or when its occupant leaves this cycle.
   assign s3_en    = !o_vld || out_ready;
   assign s2_en    = !s2_vld || s3_en;
   assign s1_en    = !s1_vld || s2_en;
   assign in_ready = s1_en;

   logic            neg;
   logic [IN_W-1:0] mag_in;
   logic            s1_sign, s1_rne;
   logic [IN_W-1:0] s1_mag;

   assign neg    = SIGNED && in_data[IN_W-1];
   assign mag_in = neg ? (~in_data + IN_W'(1)) : in_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_sign <= 1'b0;
         s1_rne  <= 1'b0;
         s1_mag  <= '0;
      end else if (s1_en) begin
         s1_vld <= in_valid;
         if (in_valid) begin
            s1_sign <= neg;
            s1_rne  <= in_rne;
            s1_mag  <= mag_in;
         end
      end
   end

   logic [PW-1:0]   lz_p, s2_p;
   logic            lz_zero, s2_zero;
   logic            s2_sign, s2_rne;
   logic [IN_W-1:0] s2_mag;

   lzd_prio #(.W(IN_W), .PW(PW)) u_lzd (
      .v    (s1_mag),
      .p    (lz_p),
      .zero (lz_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld  <= 1'b0;
         s2_sign <= 1'b0;
         s2_rne  <= 1'b0;
         s2_mag  <= '0;
         s2_p    <= '0;
         s2_zero <= 1'b0;
      end else if (s2_en) begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_sign <= s1_sign;
            s2_rne  <= s1_rne;
            s2_mag  <= s1_mag;
            s2_p    <= lz_p;
            s2_zero <= lz_zero;
         end
      end
   end

   f_res_t          res_n, res;
   logic [EW-1:0]   sh, e_n;
   logic [IN_W-1:0] shifted, rem, half;
   logic [IN_W:0]   man_r;
   logic            up;

   always_comb begin
      res_n      = '0;
      res_n.sign = s2_sign;
      sh         = '0;
      e_n        = '0;
      shifted    = '0;
      rem        = '0;
      half       = '0;
      man_r      = '0;
      up         = 1'b0;
      if (s2_zero) begin
         res_n.man = '0;
      end else if (EW'(s2_p) < EW'(MAN_W)) begin
         res_n.man = s2_mag[MAN_W-1:0];
      end else begin
         sh      = EW'(s2_p) - EW'(MAN_W - 1);
         shifted = s2_mag >> sh;
         rem     = s2_mag & ((IN_W'(1) << sh) - IN_W'(1));
         half    = IN_W'(1) << (sh - EW'(1));
         up      = (s2_rne == RND_RNE) && ((rem > half) || ((rem == half) && shifted[0]));
         man_r   = {1'b0, shifted} + IW1'(up);
         e_n     = sh;
         // A round-up carry out of the mantissa renormalises to 1.000 at the next exponent.
         if (|man_r[IN_W:MAN_W]) begin
            man_r = IW1'(1) << (MAN_W - 1);
            e_n   = sh + EW'(1);
         end
         if (e_n > EW'(MAXE)) begin
            res_n.exp     = '1;
            res_n.man     = '1;
            res_n.inexact = 1'b1;
            res_n.sat     = 1'b1;
         end else begin
            res_n.exp     = e_n[EXP_W-1:0];
            res_n.man     = man_r[MAN_W-1:0];
            res_n.inexact = (rem != '0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_vld <= 1'b0;
         res   <= '0;
      end else if (s3_en) begin
         o_vld <= s2_vld;
         if (s2_vld) res <= res_n;
      end
   end

   assign out_valid   = o_vld;
   assign out_sign    = res.sign;
   assign out_exp     = res.exp;
   assign out_man     = res.man;
   assign out_inexact = res.inexact;
   assign out_sat     = res.sat;

endmodule

// File: tb/tb_int2float_pipe.sv
// Bench for int2float_pipe: unsigned and signed instances share stimulus, checked against an arithmetic model.
module tb_int2float_pipe;

   logic        clk, rst_n, in_valid, in_rne, out_ready;
   logic [10:0] in_data;

   logic       u_in_ready, u_out_valid, u_sign, u_inexact, u_sat;
   logic [2:0] u_exp;
   logic [3:0] u_man;
   logic       s_in_ready, s_out_valid, s_sign, s_inexact, s_sat;
   logic [2:0] s_exp;
   logic [3:0] s_man;
   logic [9:0] u_res, s_res;

   assign u_res = {u_sign, u_exp, u_man, u_inexact, u_sat};
   assign s_res = {s_sign, s_exp, s_man, s_inexact, s_sat};

   int2float_pipe #(.IN_W(11), .MAN_W(4), .EXP_W(3), .SIGNED(1'b0)) dut_u (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
      .in_data(in_data), .in_rne(in_rne), .out_valid(u_out_valid), .out_ready(out_ready),
      .out_sign(u_sign), .out_exp(u_exp), .out_man(u_man),
      .out_inexact(u_inexact), .out_sat(u_sat)
   );

   int2float_pipe #(.IN_W(11), .MAN_W(4), .EXP_W(3), .SIGNED(1'b1)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .in_rne(in_rne), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_sign(s_sign), .out_exp(s_exp), .out_man(s_man),
      .out_inexact(s_inexact), .out_sat(s_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] eu;
      logic [9:0] es;
      int         stamp;
      bit         lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0, n_pass = 0, cyc = 0;
   bit   lat_mode = 1'b0, rdone = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   // Reference: find the exponent that leaves 4 significant bits, then round in plain integers.
   function automatic logic [9:0] model(input logic [10:0] raw, input bit rne, input bit sgnd);
      int mag, e, man, rem;
      bit s, inex;
      s   = sgnd && raw[10];
      mag = s ? 2048 - int'(raw) : int'(raw);
      if (mag < 16) return {s, 3'd0, 4'(mag), 2'b00};
      e = 0;
      while ((mag >> e) >= 16) e++;
      man  = mag >> e;
      rem  = mag - (man << e);
      inex = (rem != 0);
      if (rne && ((2 * rem > (1 << e)) || ((2 * rem == (1 << e)) && (man % 2 == 1)))) man++;
      if (man == 16) begin
         man = 8;
         e++;
      end
      if (e > 7) return {s, 7'h7F, 2'b11};
      return {s, 3'(e), 4'(man), inex, 1'b0};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (u_out_valid && out_ready) begin
            if (sb.size() == 0) chk("stale_out", 1, 0);
            else begin
               mon_e = sb.pop_front();
               chk("res_unsigned", u_res, mon_e.eu);
               chk("res_signed", s_res, mon_e.es);
               chk("signed_valid", s_out_valid, 1);
               if (mon_e.lat) chk("latency", cyc - mon_e.stamp, 3);
            end
         end
         if (in_valid && u_in_ready) begin
            mon_e.eu    = model(in_data, in_rne, 1'b0);
            mon_e.es    = model(in_data, in_rne, 1'b1);
            mon_e.stamp = cyc;
            mon_e.lat   = lat_mode;
            sb.push_back(mon_e);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [10:0] v, input bit rne);
      int w;
      in_valid = 1'b1;
      in_data  = v;
      in_rne   = rne;
      w = 0;
      @(negedge clk);
      while (!u_in_ready && w < 50) begin
         w++;
         @(negedge clk);
      end
      if (w >= 50) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      out_ready = 1'b1;
      w = 0;
      while (sb.size() != 0 && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   int dv[11] = '{0, 13, 44, 42, 46, 46, 2047, 2047, 1016, 'h7FB, 'h400};
   bit dr[11] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_rne = 1'b0; out_ready = 1'b1;
      #12;
      chk("rst_out_valid", u_out_valid, 0);
      chk("rst_res_unsigned", u_res, 0);
      chk("rst_res_signed", s_res, 0);
      chk("rst_in_ready", u_in_ready, 1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      lat_mode = 1'b1;
      for (int i = 0; i < 11; i++) send(11'(dv[i]), dr[i]);
      drain();
      lat_mode = 1'b0;

      // Six back-to-back samples against a five-cycle stall.
      fork
         begin
            for (int i = 0; i < 6; i++) send(11'($urandom), 1'($urandom));
         end
         begin
            out_ready = 1'b0;
            repeat (4) @(negedge clk);
            chk("bp_in_ready_low", u_in_ready, 0);
            chk("bp_out_valid", u_out_valid, 1);
            chk("bp_hold_a", u_res, sb[0].eu);
            @(negedge clk);
            chk("bp_in_ready_low2", u_in_ready, 0);
            chk("bp_hold_b", u_res, sb[0].eu);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      rdone = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               send(11'($urandom), 1'($urandom));
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      drain();

      // Reset with three samples in flight.
      for (int i = 0; i < 3; i++) send(11'(100 + 37 * i), 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", u_out_valid, 0);
      chk("mid_rst_signed_valid", s_out_valid, 0);
      sb.delete();
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst_idle", u_out_valid, 0);
      end
      @(posedge clk);
      #1;
      lat_mode = 1'b1;
      send(11'd46, 1'b1);
      drain();
      chk("sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
      $fatal(1);
   end

endmodule
